// File: rtl/arm_enc_pkg.sv
// Shared definitions for the ARM instruction encoder: opcode and condition
// constants, the FIFO entry layout {instr, addr}, and the field-to-word
// encoding function used by both the RTL and the program generator.
package arm_enc_pkg;

  localparam logic [1:0] OP_DP   = 2'b00;
  localparam logic [1:0] OP_MEM  = 2'b01;
  localparam logic [1:0] OP_BR   = 2'b10;
  localparam logic [3:0] COND_AL = 4'hE;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } enc_entry_t;

  // Branches carry only the link/flag bits funct[5:4] plus a 24-bit offset;
  // every other major opcode uses the register/operand layout.
  function automatic logic [31:0] encode_instr(
    input logic [3:0]  cond,
    input logic [1:0]  op,
    input logic [5:0]  funct,
    input logic [3:0]  rn,
    input logic [3:0]  rd,
    input logic [11:0] src2,
    input logic [23:0] imm24
  );
    logic [31:0] word;
    if (op == OP_BR) word = {cond, OP_BR, funct[5:4], imm24};
    else             word = {cond, op, funct, rn, rd, src2};
    return word;
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// Synchronous FIFO of encoder entries with a wrap bit on each pointer.
// Ports: clk, reset_n (async, active low), clear (sync flush), push/wdata,
// pop/rdata, full, empty. rdata shows the head entry, or the last popped
// entry (zero after reset/clear) while the FIFO is empty.
module enc_fifo
  import arm_enc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       push,
  input  logic       pop,
  input  enc_entry_t wdata,
  output enc_entry_t rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0] wptr;
  logic [AW:0] rptr;
  enc_entry_t  mem [DEPTH];
  enc_entry_t  last;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
      last <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
      last <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop) begin
        rptr <= rptr + PTR_ONE;
        last <= mem[rptr[AW-1:0]];
      end
    end
  end

  // Storage needs no reset: an entry is only visible once the write pointer
  // has moved past it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = empty ? last : mem[rptr[AW-1:0]];

endmodule

// File: rtl/instr_encoder.sv
// Encodes decoded ARM instruction fields into 32-bit words, tags each with a
// sequential byte address and streams {instr, addr} out through a FIFO.
// Ports: clk, reset_n, clear; in_valid/in_ready + fields (cond, op, funct, rn,
// rd, src2, imm24); out_valid/out_ready/out_instr/out_addr; word_count, done,
// err. Optional macro INSTR_CHECK_EN drops illegal requests and flags err.
module instr_encoder
  import arm_enc_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  cond,
  input  logic [1:0]  op,
  input  logic [5:0]  funct,
  input  logic [3:0]  rn,
  input  logic [3:0]  rd,
  input  logic [11:0] src2,
  input  logic [23:0] imm24,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic [6:0]  word_count,
  output logic        done,
  output logic        err
);

  localparam logic [6:0] MAX_CNT = 7'(MAX_WORDS);

  logic       full;
  logic       empty;
  logic       accept;
  logic       illegal;
  logic       push;
  logic [31:0] next_addr;
  enc_entry_t wdata;
  enc_entry_t rdata;

  // reset_n gates in_ready directly so no handshake can complete while the
  // block is held in reset.
  assign in_ready = reset_n && !full && (word_count < MAX_CNT) && !clear;
  assign accept   = in_valid && in_ready;

`ifdef INSTR_CHECK_EN
  assign illegal = (op == 2'b11) || ((op == OP_BR) && !funct[5]);
`else
  assign illegal = 1'b0;
`endif

  // Illegal requests complete the handshake but never reach the FIFO.
  assign push = accept && !illegal;

  assign wdata.instr = encode_instr(cond, op, funct, rn, rd, src2, imm24);
  assign wdata.addr  = next_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_count <= '0;
      next_addr  <= BASE_ADDR;
    end else if (clear) begin
      word_count <= '0;
      next_addr  <= BASE_ADDR;
    end else if (push) begin
      word_count <= word_count + 7'd1;
      next_addr  <= next_addr + 32'd4;
    end
  end

`ifdef INSTR_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                err_q <= 1'b0;
    else if (clear)              err_q <= 1'b0;
    else if (accept && illegal)  err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  enc_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (push),
    .pop     (out_ready),
    .wdata   (wdata),
    .rdata   (rdata),
    .full    (full),
    .empty   (empty)
  );

  assign out_valid = !empty;
  assign out_instr = rdata.instr;
  assign out_addr  = rdata.addr;
  assign done      = (word_count == MAX_CNT) && empty;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam int          DEPTH = 4;
  localparam int          MAXW  = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  cond = '0;
  logic [1:0]  op = '0;
  logic [5:0]  funct = '0;
  logic [3:0]  rn = '0;
  logic [3:0]  rd = '0;
  logic [11:0] src2 = '0;
  logic [23:0] imm24 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic [6:0]  word_count;
  logic        done;
  logic        err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .cond(cond), .op(op), .funct(funct), .rn(rn), .rd(rd),
    .src2(src2), .imm24(imm24),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .word_count(word_count), .done(done), .err(err)
  );

  // ---------------- reference model ----------------
  logic [63:0] exp_q[$];   // {instr, addr}
  int          m_count;
  logic [31:0] m_addr;
  logic [63:0] m_last;
  logic        m_err;
  logic        m_acc;

  function automatic logic [31:0] model_word();
    logic [31:0] w;
    w = (32'(cond) << 28) | (32'(op) << 26);
    if (op == 2'd2) w = w | (32'(funct / 16) << 24) | 32'(imm24);
    else            w = w | (32'(funct) << 20) | (32'(rn) << 16) | (32'(rd) << 12) | 32'(src2);
    return w;
  endfunction

  function automatic logic model_illegal();
`ifdef INSTR_CHECK_EN
    return (op == 2'd3) || (op == 2'd2 && funct < 6'd32);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic model_ready();
    return (exp_q.size() < DEPTH) && (m_count < MAXW) && !clear && reset_n;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_count = 0;
    m_addr  = BASE;
    m_last  = '0;
    m_err   = 1'b0;
  endtask

  // Apply one clock edge to model and DUT, then settle #1 after the edge.
  task automatic step();
    logic acc;
    acc   = in_valid && model_ready();
    m_acc = acc;
    if (clear) begin
      model_reset();
    end else begin
      if (out_ready && exp_q.size() > 0) m_last = exp_q.pop_front();
      if (acc) begin
        if (model_illegal()) m_err = 1'b1;
        else begin
          exp_q.push_back({model_word(), m_addr});
          m_addr  = m_addr + 32'd4;
          m_count = m_count + 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    in_valid = 1'b0;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_reset();
  endtask

  task automatic rand_req(input bit allow_illegal);
    cond  = 4'($urandom);
    op    = 2'($urandom_range(0, 3));
    funct = 6'($urandom);
    rn    = 4'($urandom);
    rd    = 4'($urandom);
    src2  = 12'($urandom);
    imm24 = 24'($urandom);
    if (!allow_illegal) begin
      if (op == 2'd3) op = 2'd0;
      if (op == 2'd2) funct[5] = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    in_valid = 1'b1;
    rand_req(0);
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready_low got %b want 0", in_ready); end
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset_n = 1'b1;
    model_reset();
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    tests++; if (out_instr !== 32'h0 || out_addr !== 32'h0) begin fails++; $display("FAIL rst_out_data got %h/%h want 0/0", out_instr, out_addr); end
    tests++; if (word_count !== 7'd0 || done !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL rst_status got cnt=%0d done=%b err=%b want 0/0/0", word_count, done, err); end
  endtask

  task automatic test_directed();
    logic [31:0] want_i [3];
    logic [31:0] want_a [3];
    want_i[0] = 32'hE2821005; want_a[0] = 32'd0;
    want_i[1] = 32'hE5943008; want_a[1] = 32'd4;
    want_i[2] = 32'hEA000002; want_a[2] = 32'd8;
    do_clear();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cond = 4'hE; imm24 = '0; src2 = '0; rn = '0; rd = '0;
      case (i)
        0: begin op = 2'b00; funct = 6'b101000; rn = 4'd2; rd = 4'd1; src2 = 12'h005; end
        1: begin op = 2'b01; funct = 6'b011001; rn = 4'd4; rd = 4'd3; src2 = 12'h008; end
        default: begin op = 2'b10; funct = 6'b100000; imm24 = 24'h000002; end
      endcase
      in_valid = 1'b1;
      #1;
      tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL dir%0d_pre rdy=%b vld=%b want 1/0", i, in_ready, out_valid); end
      step();
      in_valid = 1'b0;
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL dir%0d_valid got %b want 1", i, out_valid); end
      tests++; if (out_instr !== want_i[i] || out_addr !== want_a[i]) begin fails++; $display("FAIL dir%0d_word got %h@%h want %h@%h", i, out_instr, out_addr, want_i[i], want_a[i]); end
      step();
    end
    tests++; if (word_count !== 7'd3 || out_valid !== 1'b0) begin fails++; $display("FAIL dir_count got %0d vld=%b want 3/0", word_count, out_valid); end
    tests++; if (out_instr !== 32'hEA000002 || out_addr !== 32'd8) begin fails++; $display("FAIL dir_hold got %h@%h want EA000002@8", out_instr, out_addr); end
  endtask

  task automatic test_illegal();
    logic [31:0] w11;
    do_clear();
    out_ready = 1'b0;
    rand_req(0);
    op = 2'b11;
    w11 = model_word();
    in_valid = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ill_ready got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    #1;
`ifdef INSTR_CHECK_EN
    tests++; if (out_valid !== 1'b0 || err !== 1'b1 || word_count !== 7'd0) begin fails++; $display("FAIL ill_drop got vld=%b err=%b cnt=%0d want 0/1/0", out_valid, err, word_count); end
    rand_req(0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || out_addr !== BASE) begin fails++; $display("FAIL ill_next_addr got vld=%b addr=%h want 1/%h", out_valid, out_addr, BASE); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL ill_sticky got %b want 1", err); end
`else
    tests++; if (out_valid !== 1'b1 || out_instr !== w11 || out_instr[27:26] !== 2'b11) begin fails++; $display("FAIL ill_word got vld=%b %h want 1/%h", out_valid, out_instr, w11); end
    tests++; if (err !== 1'b0 || word_count !== 7'd1) begin fails++; $display("FAIL ill_err got err=%b cnt=%0d want 0/1", err, word_count); end
    rand_req(0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    tests++; if (out_addr !== BASE || word_count !== 7'd2) begin fails++; $display("FAIL ill_next got addr=%h cnt=%0d want %h/2", out_addr, word_count, BASE); end
`endif
  endtask

  task automatic test_backpressure();
    int pops = 0;
    do_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_req(0);
      in_valid = 1'b1;
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_fill%0d rdy got %b want 1", i, in_ready); end
      step();
    end
    rand_req(0);
    for (int k = 0; k < 3; k++) begin
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_full%0d rdy got %b want 0", k, in_ready); end
      tests++; if (out_addr !== BASE || out_instr !== exp_q[0][63:32]) begin fails++; $display("FAIL bp_hold%0d got %h@%h want %h@%h", k, out_instr, out_addr, exp_q[0][63:32], BASE); end
      step();
    end
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_nopass rdy got %b want 0", in_ready); end
    for (int cyc = 0; cyc < 16 && (exp_q.size() > 0 || in_valid); cyc++) begin
      if (exp_q.size() > 0) begin
        tests++;
        if (out_valid !== 1'b1 || out_instr !== exp_q[0][63:32] || out_addr !== BASE + 32'(pops * 4)) begin
          fails++; $display("FAIL bp_drain%0d got %b %h@%h want 1 %h@%h", pops, out_valid, out_instr, out_addr, exp_q[0][63:32], BASE + 32'(pops * 4));
        end
        pops++;
      end
      step();
      if (m_acc) in_valid = 1'b0;
    end
    tests++; if (pops != 5 || in_valid !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL bp_timeout pops=%0d pend=%b vld=%b want 5/0/0", pops, in_valid, out_valid); end
  endtask

  task automatic test_random();
    int bad = 0;
    do_clear();
    for (int c = 0; c < 400; c++) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin rand_req(1); in_valid = 1'b1; end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      tests++;
      if (in_ready !== model_ready() || out_valid !== (exp_q.size() > 0) || word_count !== 7'(m_count) ||
          err !== m_err || done !== (m_count == MAXW && exp_q.size() == 0) ||
          (exp_q.size() > 0 && {out_instr, out_addr} !== exp_q[0]) ||
          (exp_q.size() == 0 && {out_instr, out_addr} !== m_last)) begin
        fails++;
        if (bad < 5) $display("FAIL rand_c%0d rdy=%b vld=%b %h@%h cnt=%0d err=%b done=%b want rdy=%b n=%0d cnt=%0d err=%b",
                              c, in_ready, out_valid, out_instr, out_addr, word_count, err, done,
                              model_ready(), exp_q.size(), m_count, m_err);
        bad++;
      end
      step();
      if (m_acc) in_valid = 1'b0;
    end
  endtask

  task automatic test_max_words();
    int hs = 0;
    int sent = 0;
    logic [31:0] last_pop = '1;
    do_clear();
    out_ready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (!in_valid && sent < 70) begin rand_req(0); in_valid = 1'b1; sent++; end
      #1;
      if (in_valid && in_ready) hs++;
      if (out_valid && out_ready) last_pop = out_addr;
      step();
      if (m_acc) in_valid = 1'b0;
    end
    tests++; if (hs != 64 || word_count !== 7'd64) begin fails++; $display("FAIL max_accept got hs=%0d cnt=%0d want 64/64", hs, word_count); end
    tests++; if (last_pop !== BASE + 32'd252 || out_addr !== BASE + 32'd252) begin fails++; $display("FAIL max_last_addr got %h/%h want %h", last_pop, out_addr, BASE + 32'd252); end
    tests++; if (done !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL max_done got done=%b vld=%b rdy=%b want 1/0/0", done, out_valid, in_ready); end
    in_valid = 1'b0;
    clear = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL clr_ready_during got %b want 0", in_ready); end
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_reset();
    #1;
    tests++; if (word_count !== 7'd0 || in_ready !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL clr_state got cnt=%0d rdy=%b done=%b want 0/1/0", word_count, in_ready, done); end
    tests++; if (out_instr !== 32'h0 || out_addr !== 32'h0 || out_valid !== 1'b0) begin fails++; $display("FAIL clr_out got %h@%h vld=%b want 0@0/0", out_instr, out_addr, out_valid); end
  endtask

  task automatic test_reset_mid();
    do_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin rand_req(0); in_valid = 1'b1; step(); end
    rand_req(0);
    #2;
    reset_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || word_count !== 7'd0) begin fails++; $display("FAIL midrst got vld=%b rdy=%b cnt=%0d want 0/0/0", out_valid, in_ready, word_count); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset_n = 1'b1;
    model_reset();
    #1;
    tests++; if (out_instr !== 32'h0 || out_addr !== 32'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL midrst_after got %h@%h vld=%b rdy=%b want 0@0/0/1", out_instr, out_addr, out_valid, in_ready); end
    rand_req(0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || out_addr !== BASE || {out_instr, out_addr} !== exp_q[0]) begin fails++; $display("FAIL midrst_first got %h@%h want %h", out_instr, out_addr, exp_q[0]); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_directed();
    test_illegal();
    test_backpressure();
    test_random();
    test_max_words();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
